p2s_serializer: RTL and testbench
=================================

# p2s_serializer

Parametrised parallel-to-serial converter with a valid/ready input handshake, a one-word holding buffer for gap-free back-to-back frames, and selectable bit order. It takes WIDTH-bit words from an upstream producer and emits one bit per clock with frame-start and frame-end markers. It is the next-generation serializer feeding the serial link logic, replacing the fixed 8-bit, strobe-only version.

## Interface
- WIDTH, 8, data word width; legal range 2..32
- LSB_FIRST, 1, 1 = bit 0 sent first; 0 = bit WIDTH-1 sent first
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- din  input  WIDTH  parallel word
- din_valid  input  1  din holds a word to send
- din_ready  output  1  serializer can accept a word this cycle
- d  output  1  serial data bit
- d_valid  output  1  d carries a frame bit this cycle
- serial_start  output  1  high with the first bit of a frame
- serial_end  output  1  high with the last bit of a frame
- busy  output  1  frame in progress or word held

One clock; reset is asynchronous and active-high.

## Operation
- Transfer occurs on a rising edge where din_valid && din_ready.
- States: IDLE, SHIFT, plus PARITY when the parity option is compiled in.
- IDLE: on transfer, load the shifter directly from din, clear the bit counter, go to SHIFT.
- SHIFT: one bit per cycle, shifter moves toward the output end; counter width $clog2(WIDTH+1); counter counts 0..WIDTH-1.
- A transfer during SHIFT loads the holding register (hold_full=1).
- Last data bit (counter == WIDTH-1):
  - if hold_full, move the held word into the shifter, clear hold_full, stay in SHIFT;
  - else if a transfer occurs this cycle, load din directly into the shifter, stay in SHIFT;
  - else go to IDLE.
- din_ready = !hold_full (registered, not combinational on din_valid); a word is never dropped or overwritten.
- d = 0 whenever d_valid = 0.
- busy = (state != IDLE) || hold_full.

## Timing
- All outputs registered.
- Reset values: d=0, d_valid=0, serial_start=0, serial_end=0, busy=0, din_ready=1; state IDLE; hold_full=0.
- Transfer at edge N from IDLE: first bit on d during cycle N+1 with serial_start=1; bit k during cycle N+1+k; serial_end=1 with the last bit in cycle N+WIDTH.
- Back-to-back: the next frame's first bit immediately follows the previous serial_end, with no idle cycle.
- serial_start and serial_end are never high in the same cycle.
- Reset asserted mid-frame: outputs return to reset values immediately and the frame and held word are discarded. After release, no partial frame resumes.

## Configuration
- P2S_PARITY_EN defined: after the last data bit, one PARITY cycle emits the even-parity bit (XOR of all WIDTH data bits) with d_valid=1. serial_end moves from the last data bit to the parity bit. Frame length is WIDTH+1. Holding-register and direct-load handover happen at the parity cycle.
- Not defined: no PARITY state; frame length is WIDTH.

## Structure
- Package p2s_pkg: state enum (IDLE, SHIFT, PARITY), localparam for counter width function, frame-length constant.
- Sub-module p2s_hold_buf: one-entry holding register with full flag and din_ready generation. The top level keeps the FSM, shifter and counter.

## Test plan
- Reset during frame: assert rst in the 3rd bit cycle. All outputs are 0 asynchronously and din_ready=1. After release, idle until the next transfer.
- Single word, WIDTH=8, LSB_FIRST=1, din=8'hA5: d sequence 1,0,1,0,0,1,0,1. serial_start in cycle 1 and serial_end in cycle 8 after the transfer. busy drops after the frame.
- LSB_FIRST=0, din=8'hA5: d sequence 1,0,1,0,0,1,0,1 reversed order, i.e. MSB first 1,0,1,0,0,1,0,1 from bit 7 down. The bench checks bit indices 7..0 explicitly.
- Back-to-back: present 8'h01, 8'h80, 8'hFF with din_valid held high. Expect 24 consecutive d_valid cycles with no gap and three start/end pairs. din_ready=0 while the hold register is full.
- Backpressure: present a 4th word while hold is full. It must not be accepted until din_ready=1, and it is transmitted intact afterwards.
- P2S_PARITY_EN, din=8'h07: 9-bit frame with parity bit 1. serial_end on the 9th bit. din=8'h03 gives parity bit 0.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial converter.
// Define P2S_PARITY_EN to append an even-parity bit to every frame.
package p2s_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

`ifdef P2S_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int FRAME_EXTRA = PARITY_EN ? 1 : 0;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int frame_len(input int width);
        return width + FRAME_EXTRA;
    endfunction

endpackage

// File: rtl/p2s_hold_buf.sv
// One-entry holding register that lets the next word wait while a frame
// is being shifted out; din_ready is a flop so it never follows din_valid.
module p2s_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             full_next_o,
    output logic             ready_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;
    logic             ready_q;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        // A full entry is never overwritten.
        if (push_i && !full_q) begin
            data_d = data_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            full_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            data_q  <= data_d;
            full_q  <= full_d;
            ready_q <= !full_d;
        end
    end

    assign data_o      = data_q;
    assign full_o      = full_q;
    assign full_next_o = full_d;
    assign ready_o     = ready_q;

endmodule

// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter: valid/ready input, gap-free back-to-back
// frames, selectable bit order; P2S_PARITY_EN adds a trailing parity bit.
module p2s_serializer
    import p2s_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             d,
    output logic             d_valid,
    output logic             serial_start,
    output logic             serial_end,
    output logic             busy
);

    localparam int CW        = cnt_width(WIDTH);
    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             xfer;
    logic             push, pop, load, at_end;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full, hold_full_next;

    logic d_q, d_d;
    logic valid_q, valid_d;
    logic start_q, start_d;
    logic end_q, end_d;
    logic busy_q, busy_d;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    p2s_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .data_i     (din),
        .push_i     (push),
        .pop_i      (pop),
        .data_o     (hold_data),
        .full_o     (hold_full),
        .full_next_o(hold_full_next),
        .ready_o    (din_ready)
    );

    assign xfer = din_valid && din_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        pop       = 1'b0;
        load      = 1'b0;
        at_end    = 1'b0;
        load_word = hold_full ? hold_data : din;

        unique case (state_q)
            IDLE: begin
                load = xfer;
            end
            SHIFT: begin
                if (cnt_q != LAST_BIT) begin
                    shift_d = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
                    cnt_d   = cnt_q + CW'(1);
                    push    = xfer;
                end else begin
`ifdef P2S_PARITY_EN
                    state_d = PARITY;
                    cnt_d   = cnt_q + CW'(1);
                    push    = xfer;
`else
                    at_end  = 1'b1;
`endif
                end
            end
            PARITY: begin
`ifdef P2S_PARITY_EN
                at_end  = 1'b1;
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame handover: held word first, else a word arriving now.
        if (at_end) begin
            if (hold_full || xfer) begin
                load = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end

        if (load) begin
            shift_d = load_word;
            cnt_d   = '0;
            state_d = SHIFT;
            pop     = hold_full;
        end
    end

`ifdef P2S_PARITY_EN
    logic par_q, par_d;

    assign par_d = load ? ^load_word : par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    always_comb begin
        valid_d = (state_d != IDLE);
        start_d = load;
        end_d   = valid_d && (cnt_d == LAST_SLOT);
        d_d     = 1'b0;
        if (state_d == SHIFT) begin
            d_d = out_bit(shift_d);
        end
`ifdef P2S_PARITY_EN
        if (state_d == PARITY) begin
            d_d = par_d;
        end
`endif
        busy_d = valid_d || hold_full_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            d_q     <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            d_q     <= d_d;
            valid_q <= valid_d;
            start_q <= start_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
        end
    end

    assign d            = d_q;
    assign d_valid      = valid_q;
    assign serial_start = start_q;
    assign serial_end   = end_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_p2s_serializer.sv
// Bench for p2s_serializer: an LSB-first and an MSB-first instance share
// stimulus; a frame-schedule model predicts every output per cycle.
module tb_p2s_serializer;

    localparam int W = 8;
`ifdef P2S_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif
    localparam int N = 4096;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;

    logic l_ready, l_d, l_valid, l_start, l_end, l_busy;
    logic m_ready, m_d, m_valid, m_start, m_end, m_busy;

    p2s_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(l_ready), .d(l_d), .d_valid(l_valid),
        .serial_start(l_start), .serial_end(l_end), .busy(l_busy)
    );

    p2s_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(m_ready), .d(m_d), .d_valid(m_valid),
        .serial_start(m_start), .serial_end(m_end), .busy(m_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_end = -1;
    int acc_cnt = 0;

    // Per-cycle recorded outputs and predicted outputs.
    logic [11:0] act_v [N];
    bit ev [N], es [N], ee [N], eh [N], eb [N], edl [N], edm [N];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] expv(input int c);
        logic [5:0] l, m;
        l = {!eh[c], eb[c], ee[c], es[c], ev[c], edl[c]};
        m = {!eh[c], eb[c], ee[c], es[c], ev[c], edm[c]};
        return {l, m};
    endfunction

    // Model: a word accepted at edge a starts at max(a, previous end + 1),
    // lasts L cycles, and occupies the hold slot until its frame starts.
    initial begin
        int c, a, s, e;
        bit p;
        forever begin
            @(negedge clk);
            c = cyc;
            if (c < N - 64) begin
                act_v[c] = {l_ready, l_busy, l_end, l_start, l_valid, l_d,
                            m_ready, m_busy, m_end, m_start, m_valid, m_d};
                if (rst) begin
                    for (int k = c; k < c + 64; k++) begin
                        ev[k] = 0; es[k] = 0; ee[k] = 0; eh[k] = 0;
                        eb[k] = 0; edl[k] = 0; edm[k] = 0;
                    end
                    last_end = -1;
                end else if (din_valid && !eh[c]) begin
                    a = c + 1;
                    s = (last_end + 1 > a) ? last_end + 1 : a;
                    e = s + L - 1;
                    p = ^din;
                    for (int k = a; k <= e; k++) eb[k] = 1;
                    for (int k = a; k < s; k++) eh[k] = 1;
                    for (int i = 0; i < L; i++) begin
                        ev[s + i] = 1;
                        if (i < W) begin
                            edl[s + i] = din[i];
                            edm[s + i] = din[W - 1 - i];
                        end else begin
                            edl[s + i] = p;
                            edm[s + i] = p;
                        end
                    end
                    es[s] = 1;
                    ee[e] = 1;
                    last_end = e;
                    acc_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        int n0, t;
        n0 = acc_cnt;
        t = 0;
        din = w;
        din_valid = 1'b1;
        while (acc_cnt == n0 && t < 200) begin
            step();
            t++;
        end
        if (acc_cnt == n0) begin
            miscompares++;
            $display("FAIL send_timeout word=%h got=not accepted exp=accepted", w);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (cyc <= last_end + 2 && t < 500) begin
            step();
            t++;
        end
    endtask

    task automatic test_reset();
        logic [11:0] o;
        step();
        o = {l_ready, l_busy, l_end, l_start, l_valid, l_d,
             m_ready, m_busy, m_end, m_start, m_valid, m_d};
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (o[i] !== ((i == 5 || i == 11) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL reset_val bit=%0d got=%b exp=%b", i, o[i],
                         (i == 5 || i == 11));
            end
        end
        step();
        rst = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_single();
        int t0, s;
        logic [W-1:0] w;
        w = 8'hA5;
        t0 = cyc;
        send(w);
        din_valid = 1'b0;
        s = cyc;
        wait_idle();
        vectors++;
        if (act_v[s][8] !== 1'b1 || act_v[s][2] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_start got=%b%b exp=11", act_v[s][8], act_v[s][2]);
        end
        for (int k = 0; k < W; k++) begin
            vectors++;
            if ({act_v[s + k][6], act_v[s + k][0]} !== {w[k], w[W - 1 - k]}) begin
                miscompares++;
                $display("FAIL a5_bit k=%0d got=%b%b exp=%b%b", k,
                         act_v[s + k][6], act_v[s + k][0], w[k], w[W - 1 - k]);
            end
        end
        vectors++;
        if (act_v[s + L - 1][9] !== 1'b1 || act_v[s + L + 1][10] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_end_busy got=%b%b exp=10",
                     act_v[s + L - 1][9], act_v[s + L + 1][10]);
        end
        for (int c = t0; c < cyc; c++) begin
            vectors++;
            if (act_v[c] !== expv(c)) begin
                miscompares++;
                $display("FAIL single cyc=%0d got=%b exp=%b", c, act_v[c], expv(c));
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0, s0, nv, ns, ne;
        t0 = cyc;
        send(8'h01);
        s0 = cyc;
        send(8'h80);
        send(8'hFF);
        din_valid = 1'b0;
        wait_idle();
        nv = 0; ns = 0; ne = 0;
        for (int c = s0; c < s0 + 3 * L; c++) begin
            nv += int'(act_v[c][7]);
            ns += int'(act_v[c][8]);
            ne += int'(act_v[c][9]);
        end
        vectors++;
        if (nv != 3 * L || ns != 3 || ne != 3) begin
            miscompares++;
            $display("FAIL b2b_counts got=%0d/%0d/%0d exp=%0d/3/3", nv, ns, ne, 3 * L);
        end
        for (int c = t0; c < cyc; c++) begin
            vectors++;
            if (act_v[c] !== expv(c)) begin
                miscompares++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", c, act_v[c], expv(c));
            end
        end
    endtask

    task automatic test_backpressure();
        int t0, s0, a1;
        logic [W-1:0] w3;
        w3 = 8'h96;
        t0 = cyc;
        send(8'h3C);
        s0 = cyc;
        send(8'hC3);
        a1 = cyc;
        send(8'h5A);
        send(w3);
        din_valid = 1'b0;
        wait_idle();
        vectors++;
        if (act_v[a1][11] !== 1'b0 || act_v[a1][5] !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready got=%b%b exp=00", act_v[a1][11], act_v[a1][5]);
        end
        for (int k = 0; k < W; k++) begin
            vectors++;
            if (act_v[s0 + 3 * L + k][6] !== w3[k]) begin
                miscompares++;
                $display("FAIL bp_word4 k=%0d got=%b exp=%b", k,
                         act_v[s0 + 3 * L + k][6], w3[k]);
            end
        end
        for (int c = t0; c < cyc; c++) begin
            vectors++;
            if (act_v[c] !== expv(c)) begin
                miscompares++;
                $display("FAIL bp cyc=%0d got=%b exp=%b", c, act_v[c], expv(c));
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        logic [11:0] o;
        t0 = cyc;
        send(8'h5B);
        send(8'hE1);
        din_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        o = {l_ready, l_busy, l_end, l_start, l_valid, l_d,
             m_ready, m_busy, m_end, m_start, m_valid, m_d};
        vectors++;
        if (o !== 12'b100000_100000) begin
            miscompares++;
            $display("FAIL reset_mid_async got=%b exp=100000100000", o);
        end
        repeat (2) step();
        rst = 1'b0;
        repeat (3 * L) step();
        for (int c = t0; c < cyc; c++) begin
            vectors++;
            if (act_v[c] !== expv(c)) begin
                miscompares++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", c, act_v[c], expv(c));
            end
        end
    endtask

    task automatic test_random();
        int t0, gap;
        t0 = cyc;
        for (int i = 0; i < 40; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * L) : 0;
            din_valid = 1'b0;
            repeat (gap) step();
            send(W'($urandom));
        end
        din_valid = 1'b0;
        wait_idle();
        for (int c = t0; c < cyc; c++) begin
            vectors++;
            if (act_v[c] !== expv(c)) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b exp=%b", c, act_v[c], expv(c));
            end
        end
    endtask

`ifdef P2S_PARITY_EN
    task automatic test_parity();
        int s;
        logic [W-1:0] ws [2];
        bit pb [2];
        ws[0] = 8'h07; pb[0] = 1'b1;
        ws[1] = 8'h03; pb[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send(ws[i]);
            din_valid = 1'b0;
            s = cyc;
            wait_idle();
            vectors++;
            if ({act_v[s + W][7], act_v[s + W][6], act_v[s + W][9], act_v[s + W - 1][9]}
                !== {1'b1, pb[i], 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL parity word=%h got=v%b d%b e%b e%b exp=v1 d%b e1 e0",
                         ws[i], act_v[s + W][7], act_v[s + W][6],
                         act_v[s + W][9], act_v[s + W - 1][9], pb[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef P2S_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
